poseidon2_msg_loader: RTL and testbench

- Upstream front-end of the Poseidon2 hash core.
- Collects a message of 1..15 field elements from a valid/ready stream into a local buffer.
- Launches the core with a one-cycle start pulse and the element count on size, and serves element reads while the core runs.
- Captures hash_out when done rises and presents it on a result valid/ready port. A watchdog bounds the wait for done.

---
 rtl/poseidon2_pkg.sv | 18 +
 rtl/poseidon2_msg_loader_if.sv | 33 +++
 rtl/poseidon2_elem_buf.sv | 36 +++
 rtl/poseidon2_msg_loader.sv | 146 ++++++++++++++
 tb/tb_poseidon2_msg_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/poseidon2_pkg.sv
// Shared constants and types for the Poseidon2 message loader front-end.
package poseidon2_pkg;

  localparam int ELEM_W         = 256;
  localparam int MAX_ELEMS      = 15;
  localparam int SIZE_W         = 4;
  localparam int TIMEOUT_CYCLES = 1023;

  typedef logic [ELEM_W-1:0] felem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    BUSY   = 2'd2,
    RESULT = 2'd3
  } loader_state_e;

endpackage

// File: rtl/poseidon2_msg_loader_if.sv
// Element stream, hash-core and result ports of the loader; master is the loader side.
interface poseidon2_msg_loader_if #(
  parameter int ELEM_W = 256,
  parameter int SIZE_W = 4
);

  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              core_start;
  logic [SIZE_W-1:0] core_size;
  logic [SIZE_W-1:0] core_rd_idx;
  logic [ELEM_W-1:0] core_rd_data;
  logic              core_done;
  logic [ELEM_W-1:0] core_hash;
  logic              res_valid;
  logic [ELEM_W-1:0] res_hash;
  logic              res_trunc;
  logic              res_err;
  logic              res_ready;

  modport master (
    input  in_valid, in_data, in_last, core_rd_idx, core_done, core_hash, res_ready,
    output in_ready, core_start, core_size, core_rd_data, res_valid, res_hash, res_trunc, res_err
  );

  modport slave (
    output in_valid, in_data, in_last, core_rd_idx, core_done, core_hash, res_ready,
    input  in_ready, core_start, core_size, core_rd_data, res_valid, res_hash, res_trunc, res_err
  );

endinterface

// File: rtl/poseidon2_elem_buf.sv
// Message element register file: one write port, one combinational read port masked by count.
module poseidon2_elem_buf #(
  parameter int ELEM_W    = 256,
  parameter int MAX_ELEMS = 15,
  parameter int SIZE_W    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [SIZE_W-1:0] wr_idx,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [SIZE_W-1:0] rd_idx,
  input  logic [SIZE_W-1:0] count,
  output logic [ELEM_W-1:0] rd_data
);

  logic [ELEM_W-1:0] mem_q [MAX_ELEMS];

  // Storage is deliberately not reset; the count mask hides stale entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_ELEMS; i++) begin
      if (wr_en && (wr_idx == SIZE_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // One-hot select over written entries; any index at or beyond count reads zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_ELEMS; i++) begin
      rd_data = rd_data |
                ({ELEM_W{(rd_idx == SIZE_W'(i)) && (SIZE_W'(i) < count)}} & mem_q[i]);
    end
  end

endmodule

// File: rtl/poseidon2_msg_loader.sv
// Poseidon2 front-end: buffers a 1..15 element message, launches the core, returns its hash.
module poseidon2_msg_loader #(
  parameter int ELEM_W         = poseidon2_pkg::ELEM_W,
  parameter int MAX_ELEMS      = poseidon2_pkg::MAX_ELEMS,
  parameter int SIZE_W         = poseidon2_pkg::SIZE_W,
  parameter int TIMEOUT_CYCLES = poseidon2_pkg::TIMEOUT_CYCLES
) (
  input logic                    clk,
  input logic                    rst_n,
  poseidon2_msg_loader_if.master bus
);

  import poseidon2_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e     state_q, state_d;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [SIZE_W-1:0] core_size_q, core_size_d;
  logic              core_start_q, core_start_d;
  logic              res_valid_q, res_valid_d;
  logic [ELEM_W-1:0] res_hash_q, res_hash_d;
  logic              trunc_q, trunc_d;
  logic              res_err_q, res_err_d;
  logic              done_q;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic              accept_s;
  logic              done_rise_s;

  // in_ready is forced low while reset is asserted even though state already reads IDLE.
  assign bus.in_ready   = rst_n && (state_q == IDLE);
  assign accept_s       = bus.in_valid && bus.in_ready;
  assign done_rise_s    = bus.core_done && !done_q;
  assign bus.core_start = core_start_q;
  assign bus.core_size  = core_size_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hash   = res_hash_q;
  assign bus.res_trunc  = trunc_q;
  assign bus.res_err    = res_err_q;

  poseidon2_elem_buf #(
    .ELEM_W    (ELEM_W),
    .MAX_ELEMS (MAX_ELEMS),
    .SIZE_W    (SIZE_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept_s),
    .wr_idx  (count_q),
    .wr_data (bus.in_data),
    .rd_idx  (bus.core_rd_idx),
    .count   (count_q),
    .rd_data (bus.core_rd_data)
  );

  // Next-state and output-register logic for the load/start/busy/result sequence.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    core_size_d  = core_size_q;
    core_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_hash_d   = res_hash_q;
    trunc_d      = trunc_q;
    res_err_d    = res_err_q;
    timer_d      = timer_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          count_d = count_q + SIZE_W'(1);
          if (bus.in_last || (count_q == SIZE_W'(MAX_ELEMS - 1))) begin
            state_d      = START;
            core_start_d = 1'b1;
            core_size_d  = count_q + SIZE_W'(1);
            trunc_d      = !bus.in_last;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = BUSY;
        timer_d = '0;
      end
      BUSY: begin
        if (done_rise_s) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_hash_d  = bus.core_hash;
          res_err_d   = 1'b0;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_hash_d  = '0;
          res_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          count_d     = '0;
          core_size_d = '0;
          trunc_d     = 1'b0;
          res_err_d   = 1'b0;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All control and result registers; async reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      core_size_q  <= '0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_hash_q   <= '0;
      trunc_q      <= 1'b0;
      res_err_q    <= 1'b0;
      done_q       <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      core_size_q  <= core_size_d;
      core_start_q <= core_start_d;
      res_valid_q  <= res_valid_d;
      res_hash_q   <= res_hash_d;
      trunc_q      <= trunc_d;
      res_err_q    <= res_err_d;
      done_q       <= bus.core_done;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: tb/tb_poseidon2_msg_loader.sv
// Directed, table-driven bench for poseidon2_msg_loader with hand-written reset/timeout sequences.
module tb_poseidon2_msg_loader;

  import poseidon2_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  poseidon2_msg_loader_if #(.ELEM_W(ELEM_W), .SIZE_W(SIZE_W)) bus ();

  poseidon2_msg_loader #(
    .ELEM_W         (ELEM_W),
    .MAX_ELEMS      (MAX_ELEMS),
    .SIZE_W         (SIZE_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                n;
    bit                last;
    felem_t            base;
    felem_t            hash;
    int                delay;
    int                hold;
    logic [SIZE_W-1:0] exp_size;
    bit                exp_trunc;
  } vec_t;

  vec_t vecs [5];

  function automatic felem_t elem(input felem_t base, input int i);
    return base + felem_t'(i);
  endfunction

  task automatic chk(input string name, input felem_t act, input felem_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input int idx, input felem_t exp, input string name);
    bus.core_rd_idx = SIZE_W'(idx);
    #1;
    chk(name, bus.core_rd_data, exp);
  endtask

  // Starts at a negedge; ends at the negedge of the cycle after the last beat.
  task automatic send_msg(input int n, input bit last, input felem_t base);
    for (int i = 0; i < n; i++) begin
      chk("in_ready_beat", bus.in_ready, 256'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = elem(base, i);
      bus.in_last  = last && (i == n - 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_start(input int n, input felem_t base, input logic [SIZE_W-1:0] exp_size);
    chk("core_start_hi", bus.core_start, 256'd1);
    chk("core_size", bus.core_size, exp_size);
    chk("in_ready_start", bus.in_ready, 256'd0);
    chk("res_valid_start", bus.res_valid, 256'd0);
    rd(0, elem(base, 0), "rd_first");
    rd(n - 1, elem(base, n - 1), "rd_last");
    rd(n, 256'd0, "rd_past_count");
    @(negedge clk);
    chk("core_start_lo", bus.core_start, 256'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send_msg(v.n, v.last, v.base);
    check_start(v.n, v.base, v.exp_size);
    repeat (v.delay) @(negedge clk);
    chk("res_valid_busy", bus.res_valid, 256'd0);
    bus.core_done = 1'b1;
    bus.core_hash = v.hash;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("res_valid", bus.res_valid, 256'd1);
    chk("res_hash", bus.res_hash, v.hash);
    chk("res_trunc", bus.res_trunc, v.exp_trunc);
    chk("res_err", bus.res_err, 256'd0);
    chk("core_size_res", bus.core_size, v.exp_size);
    chk("in_ready_res", bus.in_ready, 256'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 256'd1);
      chk("hold_hash", bus.res_hash, v.hash);
      chk("hold_trunc", bus.res_trunc, v.exp_trunc);
      chk("hold_in_ready", bus.in_ready, 256'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", bus.res_valid, 256'd0);
    chk("in_ready_after", bus.in_ready, 256'd1);
    chk("trunc_cleared", bus.res_trunc, 256'd0);
    rd(0, 256'd0, "count_cleared");
  endtask

  // Core never produces a fresh rising edge, so the watchdog must fire.
  task automatic run_timeout(input int n, input felem_t base, input bit pre_done);
    if (pre_done) begin
      bus.core_done = 1'b1;
      bus.core_hash = 256'hdead_beef;
    end else begin
      bus.core_done = 1'b0;
    end
    send_msg(n, 1'b1, base);
    check_start(n, base, SIZE_W'(n));
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    chk("to_not_yet", bus.res_valid, 256'd0);
    @(negedge clk);
    chk("to_valid", bus.res_valid, 256'd1);
    chk("to_err", bus.res_err, 256'd1);
    chk("to_hash", bus.res_hash, 256'd0);
    chk("to_trunc", bus.res_trunc, 256'd0);
    bus.core_done = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("to_valid_drop", bus.res_valid, 256'd0);
    chk("to_err_clear", bus.res_err, 256'd0);
    chk("to_in_ready", bus.in_ready, 256'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_in_ready"}, bus.in_ready, 256'd0);
    chk({tag, "_core_start"}, bus.core_start, 256'd0);
    chk({tag, "_core_size"}, bus.core_size, 256'd0);
    chk({tag, "_res_valid"}, bus.res_valid, 256'd0);
    chk({tag, "_res_hash"}, bus.res_hash, 256'd0);
    chk({tag, "_res_err"}, bus.res_err, 256'd0);
    rd(0, 256'd0, {tag, "_rd0"});
  endtask

  task automatic quiet_cycles(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({tag, "_no_start"}, bus.core_start, 256'd0);
      chk({tag, "_no_result"}, bus.res_valid, 256'd0);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.core_rd_idx = '0;
    bus.core_done   = 1'b0;
    bus.core_hash   = '0;
    bus.res_ready   = 1'b0;

    vecs[0] = '{n: 1,  last: 1'b1, base: 256'h0a11ce, hash: 256'h1234_5678_9abc, delay: 0, hold: 0,  exp_size: 4'd1,  exp_trunc: 1'b0};
    vecs[1] = '{n: 15, last: 1'b0, base: 256'h1000,   hash: 256'hfeed_f00d,      delay: 3, hold: 0,  exp_size: 4'd15, exp_trunc: 1'b1};
    vecs[2] = '{n: 15, last: 1'b1, base: 256'h2000,   hash: 256'hcafe,           delay: 1, hold: 0,  exp_size: 4'd15, exp_trunc: 1'b0};
    vecs[3] = '{n: 4,  last: 1'b1, base: 256'h3000,   hash: 256'h5a5a_a5a5,      delay: 5, hold: 20, exp_size: 4'd4,  exp_trunc: 1'b0};
    vecs[4] = '{n: 9,  last: 1'b1, base: {4'hf, 252'd7}, hash: {256{1'b1}},      delay: 2, hold: 2,  exp_size: 4'd9,  exp_trunc: 1'b0};

    check_reset_outputs("por");
    chk("por_trunc", bus.res_trunc, 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 256'd1);

    for (int v = 0; v < 5; v++) begin
      run_vec(vecs[v]);
    end

    run_timeout(7, 256'h7000, 1'b0);
    run_timeout(3, 256'h8000, 1'b1);

    // Reset while the third beat of a five-element message is on the bus.
    send_msg(2, 1'b0, 256'h9000);
    bus.in_valid = 1'b1;
    bus.in_data  = elem(256'h9000, 2);
    #2;
    rst_n = 1'b0;
    check_reset_outputs("rst_load");
    rd(1, 256'd0, "rst_load_rd1");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles(3, "after_rst_load");
    run_vec('{n: 4, last: 1'b1, base: 256'ha000, hash: 256'h4444, delay: 1, hold: 0, exp_size: 4'd4, exp_trunc: 1'b0});

    // Reset while the core is busy; a later done edge must not produce a result.
    send_msg(3, 1'b1, 256'hb000);
    check_start(3, 256'hb000, 4'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    check_reset_outputs("rst_busy");
    @(negedge clk);
    rst_n = 1'b1;
    bus.core_done = 1'b1;
    bus.core_hash = 256'h6666;
    quiet_cycles(1, "late_done");
    bus.core_done = 1'b0;
    quiet_cycles(3, "after_rst_busy");
    run_vec('{n: 2, last: 1'b1, base: 256'hc000, hash: 256'h2222, delay: 0, hold: 1, exp_size: 4'd2, exp_trunc: 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
